// File: rtl/iomem_arb2.sv
// iomem_arb2: two-master round-robin arbiter for the PicoSoC iomem bus.
// Master 0 (CPU iomem port) and master 1 (e.g. display refresh or DMA) share
// one iomem target. Grants are registered and are always separated by one idle
// cycle, so a registered target ready can never leak into the next owner.
// Optional macro IOMEM_ARB_TIMEOUT_EN adds a watchdog that force-completes a
// grant after TIMEOUT cycles without s_ready and sets the sticky err flag.
module iomem_arb2 #(
   parameter int          TIMEOUT       = 16,
   parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic        r_lastOwner;
   logic        w_selM1;
   logic        w_selValid;
   logic [3:0]  w_selWstrb;
   logic [31:0] w_selAddr;
   logic [31:0] w_selWdata;
   logic        w_ready;
   logic [31:0] w_rdata;

`ifdef IOMEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             w_timeout;
`else
   logic w_unusedCfg;
   assign w_unusedCfg = ^{TIMEOUT_RDATA, 32'(TIMEOUT)};
`endif

   // The owner's request fields are what the target sees while a grant is open
   assign w_selM1    = (r_state == GNT1);
   assign w_selValid = w_selM1 ? m1_valid : m0_valid;
   assign w_selWstrb = w_selM1 ? m1_wstrb : m0_wstrb;
   assign w_selAddr  = w_selM1 ? m1_addr  : m0_addr;
   assign w_selWdata = w_selM1 ? m1_wdata : m0_wdata;

   // Completion and read data go only to the owner; the waiting master sees zeros
   assign m0_ready = w_ready & ~w_selM1;
   assign m1_ready = w_ready &  w_selM1;
   assign m0_rdata = w_selM1 ? 32'h0 : w_rdata;
   assign m1_rdata = w_selM1 ? w_rdata : 32'h0;

   // Arbitration, bus muxing and grant termination (completion, abandon, timeout)
   always_comb begin
      w_nextState = r_state;
      s_valid     = 1'b0;
      s_wstrb     = 4'h0;
      s_addr      = 32'h0;
      s_wdata     = 32'h0;
      w_ready     = 1'b0;
      w_rdata     = 32'h0;
      grant       = 2'b00;
`ifdef IOMEM_ARB_TIMEOUT_EN
      w_timeout   = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (m0_valid && m1_valid) begin
               w_nextState = r_lastOwner ? GNT0 : GNT1;
            end else if (m0_valid) begin
               w_nextState = GNT0;
            end else if (m1_valid) begin
               w_nextState = GNT1;
            end
         end
         GNT0, GNT1: begin
            grant   = w_selM1 ? 2'b10 : 2'b01;
            s_valid = w_selValid;
            s_wstrb = w_selWstrb;
            s_addr  = w_selAddr;
            s_wdata = w_selWdata;
            w_ready = s_ready;
            w_rdata = s_rdata;
            if (s_ready || !w_selValid) begin
               w_nextState = IDLE;
            end
`ifdef IOMEM_ARB_TIMEOUT_EN
            else if (r_cnt == CNT_MAX) begin
               s_valid     = 1'b0;
               w_ready     = 1'b1;
               w_rdata     = TIMEOUT_RDATA;
               w_timeout   = 1'b1;
               w_nextState = IDLE;
            end
`endif
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State register; the master leaving a grant becomes the low-priority one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_lastOwner <= 1'b1;
      end else begin
         r_state <= w_nextState;
         if (r_state != IDLE && w_nextState == IDLE) begin
            r_lastOwner <= w_selM1;
         end
      end
   end

`ifdef IOMEM_ARB_TIMEOUT_EN
   // Grant-age counter restarts in IDLE so the first grant cycle sees zero; err is sticky
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_arb2.sv
// tb_iomem_arb2: directed scenarios plus randomized traffic for iomem_arb2,
// compared every cycle against a transaction-level model of the arbiter.
module tb_iomem_arb2;

   localparam int          TO       = 16;
   localparam logic [31:0] TO_RDATA = 32'hDEAD_BEEF;

   logic        clk;
   logic        reset;
   logic        m0_valid, m1_valid;
   logic        m0_ready, m1_ready;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
   logic        s_valid, s_ready;
   logic [3:0]  s_wstrb;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [1:0]  grant;
   logic        err;

   iomem_arb2 #(.TIMEOUT(TO), .TIMEOUT_RDATA(TO_RDATA)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
      .grant(grant), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChecks = 0;
   int nErrors = 0;

   // Reference model: who owns the bus (0 none, 1 m0, 2 m1), who was served
   // last, how long the current grant has been open, and the sticky error.
   int   mOwner;
   bit   mLastM1;
   int   mCnt;
   bit   mErr;
   bit   mHit;

   logic [1:0]  eGrant;
   logic        eSValid, eR0, eR1;
   logic [3:0]  eSWstrb;
   logic [31:0] eSAddr, eSWdata, eD0, eD1;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mOwner  = 0;
      mLastM1 = 1'b1;
      mCnt    = 0;
      mErr    = 1'b0;
      mHit    = 1'b0;
   endtask

   // Wait for the falling edge, derive expected outputs from the model and compare all of them
   task automatic checkOutput(input string tag);
      logic        vk;
      logic [3:0]  wk;
      logic [31:0] ak, dk;
      @(negedge clk);
      eGrant = 2'b00; eSValid = 1'b0; eSWstrb = 4'h0; eSAddr = 32'h0; eSWdata = 32'h0;
      eR0 = 1'b0; eR1 = 1'b0; eD0 = 32'h0; eD1 = 32'h0; mHit = 1'b0;
      if (mOwner != 0 && !reset) begin
         vk = (mOwner == 1) ? m0_valid : m1_valid;
         wk = (mOwner == 1) ? m0_wstrb : m1_wstrb;
         ak = (mOwner == 1) ? m0_addr  : m1_addr;
         dk = (mOwner == 1) ? m0_wdata : m1_wdata;
`ifdef IOMEM_ARB_TIMEOUT_EN
         mHit = !s_ready && vk && (mCnt == TO - 1);
`endif
         eGrant  = (mOwner == 1) ? 2'b01 : 2'b10;
         eSValid = vk && !mHit;
         eSWstrb = wk;
         eSAddr  = ak;
         eSWdata = dk;
         if (mOwner == 1) begin
            eR0 = s_ready || mHit;
            eD0 = mHit ? TO_RDATA : s_rdata;
         end else begin
            eR1 = s_ready || mHit;
            eD1 = mHit ? TO_RDATA : s_rdata;
         end
      end
      cmp({tag, " grant"},    32'(grant),    32'(eGrant));
      cmp({tag, " s_valid"},  32'(s_valid),  32'(eSValid));
      cmp({tag, " s_wstrb"},  32'(s_wstrb),  32'(eSWstrb));
      cmp({tag, " s_addr"},   s_addr,        eSAddr);
      cmp({tag, " s_wdata"},  s_wdata,       eSWdata);
      cmp({tag, " m0_ready"}, 32'(m0_ready), 32'(eR0));
      cmp({tag, " m1_ready"}, 32'(m1_ready), 32'(eR1));
      cmp({tag, " m0_rdata"}, m0_rdata,      eD0);
      cmp({tag, " m1_rdata"}, m1_rdata,      eD1);
      cmp({tag, " err"},      32'(err),      32'(mErr));
   endtask

   // Advance the model by one transaction-level step, then clock the DUT
   task automatic applyStimulus();
      logic vk;
      if (mOwner == 0) begin
         if (m0_valid && m1_valid) mOwner = mLastM1 ? 1 : 2;
         else if (m0_valid)        mOwner = 1;
         else if (m1_valid)        mOwner = 2;
         mCnt = 0;
      end else begin
         vk = (mOwner == 1) ? m0_valid : m1_valid;
         if (s_ready || !vk || mHit) begin
            if (mHit) mErr = 1'b1;
            mLastM1 = (mOwner == 2);
            mOwner  = 0;
         end else begin
            mCnt++;
         end
      end
      mHit = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
      m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
      s_ready = 1'b0; s_rdata = 32'h0;
      modelReset();
      checkOutput("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         n;
      logic [1:0] seq [6];
      bit         pend0, pend1, done0, done1;

      doReset();

      // Test 1: single m0 read, target answers two cycles after s_valid
      m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0300_0004;
      checkOutput("t1 idle");
      cmp("t1 idle grant", 32'(grant), 32'h0);
      applyStimulus();
      checkOutput("t1 g1");
      cmp("t1 grant01", 32'(grant), 32'h1);
      applyStimulus();
      checkOutput("t1 g2");
      applyStimulus();
      s_ready = 1'b1; s_rdata = 32'h1234_5678;
      checkOutput("t1 g3");
      cmp("t1 m0_ready", 32'(m0_ready), 32'h1);
      cmp("t1 m0_rdata", m0_rdata, 32'h1234_5678);
      applyStimulus();
      s_ready = 1'b0; m0_valid = 1'b0;
      checkOutput("t1 after");
      cmp("t1 back idle", 32'(grant), 32'h0);
      applyStimulus();

      // Test 2: simultaneous writes after reset, m0 first then m1 with an idle gap
      doReset();
      m0_valid = 1'b1; m0_wstrb = 4'hF; m0_addr = 32'h0300_0000; m0_wdata = 32'hA5A5_A5A5;
      m1_valid = 1'b1; m1_wstrb = 4'hF; m1_addr = 32'h0300_0008; m1_wdata = 32'h5A5A_5A5A;
      checkOutput("t2 idle");
      applyStimulus();
      s_ready = 1'b1;
      checkOutput("t2 m0");
      cmp("t2 grant m0", 32'(grant), 32'h1);
      cmp("t2 wdata m0", s_wdata, 32'hA5A5_A5A5);
      applyStimulus();
      m0_valid = 1'b0; s_ready = 1'b0;
      checkOutput("t2 gap");
      cmp("t2 gap grant", 32'(grant), 32'h0);
      applyStimulus();
      s_ready = 1'b1;
      checkOutput("t2 m1");
      cmp("t2 grant m1", 32'(grant), 32'h2);
      cmp("t2 wdata m1", s_wdata, 32'h5A5A_5A5A);
      applyStimulus();
      m1_valid = 1'b0; s_ready = 1'b0;
      checkOutput("t2 end");
      applyStimulus();

      // Test 3: both masters hold valid for six transactions, grants must alternate
      m0_valid = 1'b1; m1_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 6; c++) begin
         s_ready = (mOwner != 0);
         checkOutput("t3");
         if (grant != 2'b00) begin
            seq[n] = grant;
            n++;
         end
         applyStimulus();
      end
      cmp("t3 count", 32'(n), 32'd6);
      for (int i = 0; i < 6; i++) begin
         cmp($sformatf("t3 seq%0d", i), 32'(seq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      end
      m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
      checkOutput("t3 end");
      applyStimulus();

      // Test 6: asynchronous reset in the middle of a GNT0 cycle
      m0_valid = 1'b1; m0_addr = 32'h0300_0010; m0_wstrb = 4'h0;
      checkOutput("t6 idle");
      applyStimulus();
      checkOutput("t6 gnt0");
      #2;
      reset = 1'b1;
      #1;
      cmp("t6 async s_valid", 32'(s_valid), 32'h0);
      cmp("t6 async grant", 32'(grant), 32'h0);
      cmp("t6 async ready", 32'(m0_ready), 32'h0);
      modelReset();
      m1_valid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("t6 rel");
      applyStimulus();
      s_ready = 1'b1;
      checkOutput("t6 first");
      cmp("t6 m0 first", 32'(grant), 32'h1);
      applyStimulus();
      m0_valid = 1'b0;
      checkOutput("t6 gap");
      applyStimulus();
      checkOutput("t6 m1");
      applyStimulus();
      m1_valid = 1'b0; s_ready = 1'b0;
      checkOutput("t6 end");
      applyStimulus();

`ifdef IOMEM_ARB_TIMEOUT_EN
      // Test 4: target never answers, m1 is force-completed on the 16th grant cycle
      doReset();
      m1_valid = 1'b1; m1_wstrb = 4'h0; m1_addr = 32'h0300_0020;
      checkOutput("t4 idle");
      applyStimulus();
      for (int i = 1; i <= TO; i++) begin
         checkOutput("t4 wait");
         if (i == TO) begin
            cmp("t4 to ready", 32'(m1_ready), 32'h1);
            cmp("t4 to rdata", m1_rdata, TO_RDATA);
            cmp("t4 to s_valid", 32'(s_valid), 32'h0);
         end else begin
            cmp("t4 no ready", 32'(m1_ready), 32'h0);
         end
         applyStimulus();
      end
      m1_valid = 1'b0;
      checkOutput("t4 after");
      cmp("t4 err set", 32'(err), 32'h1);
      applyStimulus();
      m1_valid = 1'b1;
      checkOutput("t4 idle2");
      applyStimulus();
      s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
      checkOutput("t4 normal");
      cmp("t4 normal rdata", m1_rdata, 32'h0BAD_F00D);
      applyStimulus();
      m1_valid = 1'b0; s_ready = 1'b0;
      checkOutput("t4 end");
      cmp("t4 err sticky", 32'(err), 32'h1);
      applyStimulus();

      // Test 5: s_ready on exactly the timeout cycle wins, err stays clear
      doReset();
      m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0300_0030;
      checkOutput("t5 idle");
      applyStimulus();
      for (int i = 1; i < TO; i++) begin
         checkOutput("t5 wait");
         applyStimulus();
      end
      s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
      checkOutput("t5 edge");
      cmp("t5 rdata", m0_rdata, 32'hCAFE_F00D);
      cmp("t5 s_valid", 32'(s_valid), 32'h1);
      applyStimulus();
      m0_valid = 1'b0; s_ready = 1'b0;
      checkOutput("t5 end");
      cmp("t5 err clear", 32'(err), 32'h0);
      applyStimulus();
`endif

      // Randomized traffic: masters obey the hold protocol except for rare drops
      doReset();
      pend0 = 1'b0; pend1 = 1'b0; done0 = 1'b0; done1 = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if (done0 || (pend0 && $urandom_range(0, 39) == 0)) begin
            pend0 = 1'b0; m0_valid = 1'b0;
         end else if (!pend0 && $urandom_range(0, 2) == 0) begin
            pend0 = 1'b1; m0_valid = 1'b1;
            m0_wstrb = 4'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
         end
         if (done1 || (pend1 && $urandom_range(0, 39) == 0)) begin
            pend1 = 1'b0; m1_valid = 1'b0;
         end else if (!pend1 && $urandom_range(0, 2) == 0) begin
            pend1 = 1'b1; m1_valid = 1'b1;
            m1_wstrb = 4'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
         end
         s_ready = (mOwner != 0) && ($urandom_range(0, 2) == 0);
         s_rdata = $urandom;
         checkOutput("rand");
         done0 = eR0;
         done1 = eR1;
         applyStimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
